// File: rtl/gf22_pad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf22_pad_pkg                                                         |
// | Shared attribute-bit indices and sequencer state encoding.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gf22_pad_pkg;

    localparam int PAD_ATTR_PWROK   = 0;
    localparam int PAD_ATTR_IOPWROK = 1;
    localparam int PAD_ATTR_BIAS    = 2;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_UP_BIAS = 3'd1,
        ST_UP_IO   = 3'd2,
        ST_UP_CORE = 3'd3,
        ST_READY   = 3'd4,
        ST_DN_CORE = 3'd5,
        ST_DN_IO   = 3'd6,
        ST_DN_BIAS = 3'd7
    } pad_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/gf22_pad_seq_delay_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf22_pad_seq_delay_cnt                                               |
// | Loadable down-counter that parks at zero.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gf22_pad_seq_delay_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/gf22_pad_pwr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf22_pad_pwr_sequencer                                               |
// | Orders BIAS/IOPWROK/PWROK and gates pad output enables.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gf22_pad_pwr_sequencer
    import gf22_pad_pkg::*;
#(
    parameter int PADATTR  = 16,
    parameter int NUM_PADS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    bias_dly_i,
    input  logic [CNT_W-1:0]    io_dly_i,
    input  logic [CNT_W-1:0]    core_dly_i,
    input  logic [NUM_PADS-1:0] pad_oe_req_i,
    output logic [NUM_PADS-1:0] pad_oe_o,
    output logic [PADATTR-1:0]  pad_attributes_o,
    output logic                ready_o,
    output logic                busy_o
);

    pad_seq_state_e      r_state;
    pad_seq_state_e      w_next;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_val;
    logic                w_cnt_zero;
    logic [NUM_PADS-1:0] r_pad_oe;
    logic [PADATTR-1:0]  w_attr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_OFF;
            r_pad_oe <= '0;
        end else begin
            r_state  <= w_next;
            r_pad_oe <= (r_state == ST_READY && start_i) ? pad_oe_req_i : '0;
        end
    end

    // Aborts during power-up take priority over counter expiry.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_OFF:     if (start_i) w_next = ST_UP_BIAS;
            ST_UP_BIAS: if (!start_i) w_next = ST_DN_BIAS; else if (w_cnt_zero) w_next = ST_UP_IO;
            ST_UP_IO:   if (!start_i) w_next = ST_DN_IO;   else if (w_cnt_zero) w_next = ST_UP_CORE;
            ST_UP_CORE: if (!start_i) w_next = ST_DN_CORE; else if (w_cnt_zero) w_next = ST_READY;
            ST_READY:   if (!start_i) w_next = ST_DN_CORE;
            ST_DN_CORE: if (w_cnt_zero) w_next = ST_DN_IO;
            ST_DN_IO:   if (w_cnt_zero) w_next = ST_DN_BIAS;
            ST_DN_BIAS: if (w_cnt_zero) w_next = ST_OFF;
            default:    w_next = ST_OFF;
        endcase
    end

    // Delay is captured only on the edge that enters a timed state.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_next != r_state) begin
            unique case (w_next)
                ST_UP_BIAS, ST_DN_BIAS: begin w_load = 1'b1; w_load_val = bias_dly_i; end
                ST_UP_IO,   ST_DN_IO:   begin w_load = 1'b1; w_load_val = io_dly_i;   end
                ST_UP_CORE, ST_DN_CORE: begin w_load = 1'b1; w_load_val = core_dly_i; end
                default:                begin w_load = 1'b0; w_load_val = '0;         end
            endcase
        end
    end

    gf22_pad_seq_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_load),
        .val_i  (w_load_val),
        .zero_o (w_cnt_zero)
    );

    always_comb begin
        w_attr = '0;
        unique case (r_state)
            ST_UP_BIAS, ST_DN_BIAS: begin
                w_attr[PAD_ATTR_BIAS] = 1'b1;
            end
            ST_UP_IO, ST_DN_IO: begin
                w_attr[PAD_ATTR_BIAS]    = 1'b1;
                w_attr[PAD_ATTR_IOPWROK] = 1'b1;
            end
            ST_UP_CORE, ST_READY, ST_DN_CORE: begin
                w_attr[PAD_ATTR_BIAS]    = 1'b1;
                w_attr[PAD_ATTR_IOPWROK] = 1'b1;
                w_attr[PAD_ATTR_PWROK]   = 1'b1;
            end
            default: w_attr = '0;
        endcase
    end

    assign pad_attributes_o = w_attr;
    assign pad_oe_o         = r_pad_oe;
    assign ready_o          = (r_state == ST_READY);
    assign busy_o           = (r_state != ST_OFF) && (r_state != ST_READY);

endmodule
`default_nettype wire
